// File: rtl/sseg_pkg.sv
// Shared types and constants for the multiplexed seven-segment driver.
package sseg_pkg;

  typedef logic [1:0] digit_idx_t;

  localparam logic [3:0] ANODE_OFF     = 4'b1111;
  localparam logic [6:0] CATHODE_BLANK = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a}; entry n is the glyph for hex digit n.
  localparam logic [6:0] FONT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/sseg_hex_font.sv
// Combinational hex-nibble to active-low seven-segment pattern lookup.
module sseg_hex_font
  import sseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  assign pattern = FONT[nibble];

endmodule

// File: rtl/sseg_scan_driver.sv
// Four-digit common-anode scan driver: prescaler, digit counter, frame latch,
// leading-zero blanking and registered anode/cathode outputs.
//
//   dig | meaning
//   0   | driving digit 0 (rightmost, value[3:0])
//   1   | driving digit 1
//   2   | driving digit 2
//   3   | driving digit 3; its last cycle latches a new frame into shadow
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter bit LZ_BLANK    = 1'b1
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        en,
  output logic [6:0]  sseg_cathode,
  output logic [3:0]  sseg_anode
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] div_cnt;
  digit_idx_t       dig;
  logic [15:0]      shadow;
  logic             tick;
  logic [3:0]       blank;
  logic [3:0]       nibble;
  logic [6:0]       pattern;

  assign tick   = (div_cnt == DIV_LAST);
  assign nibble = shadow[{dig, 2'b00} +: 4];

  // A digit is blank only if it and every nibble above it are zero; digit 0 always shows.
  always_comb begin
    blank = 4'b0000;
    if (LZ_BLANK) begin
      blank[3] = (shadow[15:12] == 4'h0);
      blank[2] = (shadow[15:8]  == 8'h00);
      blank[1] = (shadow[15:4]  == 12'h000);
    end
  end

  sseg_hex_font u_font (
    .nibble  (nibble),
    .pattern (pattern)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt      <= '0;
      dig          <= 2'd0;
      shadow       <= 16'h0000;
      sseg_anode   <= ANODE_OFF;
      sseg_cathode <= CATHODE_BLANK;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        dig <= dig + 1'b1;
      end
      if (tick && dig == 2'd3) begin
        shadow <= value;
      end
      if (en && !blank[dig]) begin
        sseg_anode   <= ~(4'b0001 << dig);
        sseg_cathode <= pattern;
      end else begin
        sseg_anode   <= ANODE_OFF;
        sseg_cathode <= CATHODE_BLANK;
      end
    end
  end

endmodule
